jtag_dtm_tap: RTL and testbench

- JTAG Debug Transport Module TAP on the target side of the JTAG link.
- Answers the IR/DR scan sequences that a JTAG host (bench or external probe) drives on TCK/TMS/TDI.
- Decodes DMI accesses into a valid/ready request toward the debug module and returns the response data on TDO in the next DR scan.
- TCK is oversampled in the system clock domain, so the block has one clock.

---
 rtl/jtag_dtm_tap.sv | 211 +++++++++++++++++++++
 tb/tb_jtag_dtm_tap.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtag_dtm_tap.sv
// jtag_dtm_tap: JTAG Debug Transport Module TAP, target side of the link.
// TCK/TMS/TDI are oversampled in the clk domain. An IEEE 1149.1 TAP controller
// selects IDCODE, DTMCS, DMI or BYPASS data registers. DMI updates become
// valid/ready requests toward the debug module. Responses come back on the
// next DMI capture.
//
// Optional build macro: JTAG_BUSY_STICKY_EN
//   When defined, a DMI request issued while busy sets a sticky dmistat=3.
//   That blocks later requests until a DTMCS write with dmireset=1.
//
// Ports:
//   clk, rst            system clock, async active-low reset
//   jtag_TCK/TMS/TDI    JTAG inputs (asynchronous to clk)
//   jtag_TDO            JTAG data out, changes only while TCK is low
//   dm_req_*            DMI request {addr, data[31:0], op[1:0]}, valid/ready
//   dm_resp_*           DMI response read data, valid/ready
module jtag_dtm_tap #(
  parameter int unsigned DMI_ABITS  = 6,
  parameter logic [31:0] IDCODE_VAL = 32'h1e200a6d,
  parameter int unsigned IR_BITS    = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   jtag_TCK,
  input  logic                   jtag_TMS,
  input  logic                   jtag_TDI,
  output logic                   jtag_TDO,
  output logic                   dm_req_valid,
  input  logic                   dm_req_ready,
  output logic [DMI_ABITS+33:0]  dm_req_data,
  input  logic                   dm_resp_valid,
  input  logic [31:0]            dm_resp_data,
  output logic                   dm_resp_ready
);

  localparam int unsigned DR_W = DMI_ABITS + 34;

  localparam logic [IR_BITS-1:0] IR_IDCODE = IR_BITS'(32'h01);
  localparam logic [IR_BITS-1:0] IR_DTMCS  = IR_BITS'(32'h10);
  localparam logic [IR_BITS-1:0] IR_DMI    = IR_BITS'(32'h11);

  typedef enum logic [3:0] {
    TLR, RTI,
    SEL_DR, CAP_DR, SH_DR, EX1_DR, PA_DR, EX2_DR, UPD_DR,
    SEL_IR, CAP_IR, SH_IR, EX1_IR, PA_IR, EX2_IR, UPD_IR
  } tap_state_e;

  tap_state_e tap_q, tap_d;

  logic [1:0] tck_sync, tms_sync, tdi_sync;
  logic       tck_d;
  logic       tck_rise, tck_fall, tms_s, tdi_s;

  logic [IR_BITS-1:0]   ir, ir_sr;
  logic [DR_W-1:0]      dr_sr, dr_cap;
  logic                 busy;
  logic [1:0]           dmistat;
  logic [31:0]          resp_data;
  logic [DMI_ABITS-1:0] last_addr;

  logic        is_idcode, is_dtmcs, is_dmi;
  logic [1:0]  dmi_status;
  logic [31:0] dtmcs_val;
  logic        req_blocked;

  // Two-flop synchronizers plus one delayed TCK sample for edge detection
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tck_sync <= '0;
      tms_sync <= '0;
      tdi_sync <= '0;
      tck_d    <= 1'b0;
    end else begin
      tck_sync <= {tck_sync[0], jtag_TCK};
      tms_sync <= {tms_sync[0], jtag_TMS};
      tdi_sync <= {tdi_sync[0], jtag_TDI};
      tck_d    <= tck_sync[1];
    end
  end

  assign tck_rise = tck_sync[1] & ~tck_d;
  assign tck_fall = ~tck_sync[1] & tck_d;
  assign tms_s    = tms_sync[1];
  assign tdi_s    = tdi_sync[1];

  // TAP controller state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) tap_q <= TLR;
    else      tap_q <= tap_d;
  end

  // TAP controller next state, advanced only on a TCK rise
  always_comb begin
    tap_d = tap_q;
    if (tck_rise) begin
      case (tap_q)
        TLR:     tap_d = tms_s ? TLR    : RTI;
        RTI:     tap_d = tms_s ? SEL_DR : RTI;
        SEL_DR:  tap_d = tms_s ? SEL_IR : CAP_DR;
        CAP_DR:  tap_d = tms_s ? EX1_DR : SH_DR;
        SH_DR:   tap_d = tms_s ? EX1_DR : SH_DR;
        EX1_DR:  tap_d = tms_s ? UPD_DR : PA_DR;
        PA_DR:   tap_d = tms_s ? EX2_DR : PA_DR;
        EX2_DR:  tap_d = tms_s ? UPD_DR : SH_DR;
        UPD_DR:  tap_d = tms_s ? SEL_DR : RTI;
        SEL_IR:  tap_d = tms_s ? TLR    : CAP_IR;
        CAP_IR:  tap_d = tms_s ? EX1_IR : SH_IR;
        SH_IR:   tap_d = tms_s ? EX1_IR : SH_IR;
        EX1_IR:  tap_d = tms_s ? UPD_IR : PA_IR;
        PA_IR:   tap_d = tms_s ? EX2_IR : PA_IR;
        EX2_IR:  tap_d = tms_s ? UPD_IR : SH_IR;
        UPD_IR:  tap_d = tms_s ? SEL_DR : RTI;
        default: tap_d = TLR;
      endcase
    end
  end

  assign is_idcode = (ir == IR_IDCODE);
  assign is_dtmcs  = (ir == IR_DTMCS);
  assign is_dmi    = (ir == IR_DMI);

  assign dmi_status = (busy || dmistat == 2'b11) ? 2'b11 : 2'b00;
  assign dtmcs_val  = {14'b0, 2'b00, 1'b0, 3'd5, dmistat, 6'(DMI_ABITS), 4'd1};

`ifdef JTAG_BUSY_STICKY_EN
  assign req_blocked = busy | (dmistat == 2'b11);
`else
  assign req_blocked = busy;
`endif

  // Capture-DR value for the selected instruction; BYPASS captures 0
  always_comb begin
    dr_cap = '0;
    if (is_dmi)         dr_cap = {last_addr, resp_data, dmi_status};
    else if (is_idcode) dr_cap = DR_W'(IDCODE_VAL);
    else if (is_dtmcs)  dr_cap = DR_W'(dtmcs_val);
  end

  // IR/DR shift paths, TDO, DMI request/response handshakes
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ir            <= IR_IDCODE;
      ir_sr         <= '0;
      dr_sr         <= '0;
      jtag_TDO      <= 1'b0;
      dm_req_valid  <= 1'b0;
      dm_req_data   <= '0;
      dm_resp_ready <= 1'b1;
      busy          <= 1'b0;
      dmistat       <= 2'b00;
      resp_data     <= '0;
      last_addr     <= '0;
    end else begin
      // Response accepted: ready drops for one clk so each response is taken once
      if (dm_resp_valid && dm_resp_ready) begin
        resp_data     <= dm_resp_data;
        busy          <= 1'b0;
        dm_resp_ready <= 1'b0;
      end else begin
        dm_resp_ready <= 1'b1;
      end

      if (dm_req_valid && dm_req_ready) dm_req_valid <= 1'b0;

      if (tap_q == TLR) ir <= IR_IDCODE;

      // State has already advanced past the rise, so Shift-* here means "still shifting"
      if (tck_fall) begin
        if (tap_q == SH_DR)      jtag_TDO <= dr_sr[0];
        else if (tap_q == SH_IR) jtag_TDO <= ir_sr[0];
        else                     jtag_TDO <= 1'b0;
      end

      if (tck_rise) begin
        case (tap_q)
          CAP_IR: ir_sr <= IR_BITS'(32'h01);
          SH_IR:  ir_sr <= {tdi_s, ir_sr[IR_BITS-1:1]};
          UPD_IR: ir    <= ir_sr;
          CAP_DR: dr_sr <= dr_cap;
          SH_DR: begin
            if (is_dmi)                     dr_sr <= {tdi_s, dr_sr[DR_W-1:1]};
            else if (is_idcode || is_dtmcs) dr_sr[31:0] <= {tdi_s, dr_sr[31:1]};
            else                            dr_sr[0] <= tdi_s;
          end
          UPD_DR: begin
            if (is_dtmcs) begin
              if (dr_sr[16]) dmistat <= 2'b00;
              if (dr_sr[17]) begin
                busy         <= 1'b0;
                dm_req_valid <= 1'b0;
              end
            end else if (is_dmi && dr_sr[1:0] != 2'b00) begin
              if (!req_blocked) begin
                dm_req_data  <= dr_sr;
                last_addr    <= dr_sr[DR_W-1:34];
                busy         <= 1'b1;
                dm_req_valid <= 1'b1;
              end else begin
`ifdef JTAG_BUSY_STICKY_EN
                dmistat <= 2'b11;
`endif
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_jtag_dtm_tap.sv
// tb_jtag_dtm_tap: directed + randomized bench for jtag_dtm_tap. A transaction-level
// model of the DTM (busy flag, sticky status, last address, response data)
// predicts every scan result and every DMI request.
module tb_jtag_dtm_tap;

  localparam int unsigned AB = 6;
  localparam int unsigned DW = AB + 34;

`ifdef JTAG_BUSY_STICKY_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          tck = 1'b0;
  logic          tms = 1'b1;
  logic          tdi = 1'b0;
  logic          tdo;
  logic          req_valid;
  logic          req_ready = 1'b0;
  logic [DW-1:0] req_data;
  logic          resp_valid = 1'b0;
  logic [31:0]   resp_data = '0;
  logic          resp_ready;

  int tests = 0;
  int fails = 0;

  jtag_dtm_tap #(.DMI_ABITS(AB), .IDCODE_VAL(32'h1e200a6d), .IR_BITS(5)) dut (
    .clk(clk), .rst(rst),
    .jtag_TCK(tck), .jtag_TMS(tms), .jtag_TDI(tdi), .jtag_TDO(tdo),
    .dm_req_valid(req_valid), .dm_req_ready(req_ready), .dm_req_data(req_data),
    .dm_resp_valid(resp_valid), .dm_resp_data(resp_data), .dm_resp_ready(resp_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  logic [AB-1:0] m_addr;
  logic [31:0]   m_resp;
  logic          m_busy;
  logic [1:0]    m_dmistat;
  logic          m_issue;
  logic [DW-1:0] m_req;

  task automatic model_reset();
    m_addr = '0; m_resp = '0; m_busy = 1'b0; m_dmistat = 2'b00; m_issue = 1'b0; m_req = '0;
  endtask

  function automatic logic [DW-1:0] model_dmi_capture();
    logic [1:0] st;
    st = (m_busy || m_dmistat == 2'd3) ? 2'd3 : 2'd0;
    return {m_addr, m_resp, st};
  endfunction

  function automatic logic [31:0] model_dtmcs_capture();
    return 32'(5 * 4096 + int'(m_dmistat) * 1024 + AB * 16 + 1);
  endfunction

  task automatic model_dmi_update(input logic [DW-1:0] v);
    m_issue = 1'b0;
    if (v[1:0] != 2'b00) begin
      if (m_busy || m_dmistat == 2'd3) begin
        if (STICKY) m_dmistat = 2'd3;
      end else begin
        m_issue = 1'b1;
        m_busy  = 1'b1;
        m_addr  = v[DW-1:34];
        m_req   = v;
      end
    end
  endtask

  task automatic model_dtmcs_update(input logic [31:0] v);
    if (v[16]) m_dmistat = 2'd0;
    if (v[17]) m_busy = 1'b0;
  endtask

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- JTAG host ----------------
  task automatic tck_cycle(input logic t_ms, input logic t_di, output logic t_do);
    t_do = tdo;
    tms = t_ms;
    tdi = t_di;
    repeat (4) @(negedge clk);
    tck = 1'b1;
    repeat (4) @(negedge clk);
    tck = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic reset_tap();
    logic d;
    for (int i = 0; i < 5; i++) tck_cycle(1'b1, 1'b0, d);
    tck_cycle(1'b0, 1'b0, d);
  endtask

  // From Run-Test/Idle back to Run-Test/Idle
  task automatic scan_ir(input logic [4:0] v, output logic [4:0] o);
    logic d;
    o = '0;
    tck_cycle(1'b1, 1'b0, d);
    tck_cycle(1'b1, 1'b0, d);
    tck_cycle(1'b0, 1'b0, d);
    tck_cycle(1'b0, 1'b0, d);
    for (int i = 0; i < 5; i++) tck_cycle(i == 4, v[i], o[i]);
    tck_cycle(1'b1, 1'b0, d);
    tck_cycle(1'b0, 1'b0, d);
  endtask

  task automatic scan_dr(input logic [DW-1:0] v, input int n, output logic [DW-1:0] o);
    logic d;
    o = '0;
    tck_cycle(1'b1, 1'b0, d);
    tck_cycle(1'b0, 1'b0, d);
    tck_cycle(1'b0, 1'b0, d);
    for (int i = 0; i < n; i++) tck_cycle(i == n - 1, v[i], o[i]);
    tck_cycle(1'b1, 1'b0, d);
    tck_cycle(1'b0, 1'b0, d);
  endtask

  task automatic set_ir(input logic [4:0] v, input string tag);
    logic [4:0] o;
    scan_ir(v, o);
    check(tag, 64'(o), 64'h01);
  endtask

  // DMI scan: check captured value, then the request (or its absence)
  task automatic dmi_scan(input logic [DW-1:0] v, input string tag);
    logic [DW-1:0] o, exp;
    exp = model_dmi_capture();
    scan_dr(v, DW, o);
    check({tag, "_capture"}, 64'(o), 64'(exp));
    model_dmi_update(v);
    check({tag, "_req_valid"}, 64'(req_valid), 64'(m_issue));
    if (m_issue) check({tag, "_req_data"}, 64'(req_data), 64'(m_req));
  endtask

  task automatic accept_req(input int delay, input string tag);
    repeat (delay) @(negedge clk);
    check({tag, "_held_valid"}, 64'(req_valid), 64'h1);
    check({tag, "_held_data"}, 64'(req_data), 64'(m_req));
    req_ready = 1'b1;
    @(negedge clk);
    check({tag, "_valid_drop"}, 64'(req_valid), 64'h0);
    req_ready = 1'b0;
  endtask

  task automatic respond(input logic [31:0] d, input string tag);
    resp_valid = 1'b1;
    resp_data  = d;
    @(negedge clk);
    resp_valid = 1'b0;
    check({tag, "_resp_ready_low"}, 64'(resp_ready), 64'h0);
    @(negedge clk);
    check({tag, "_resp_ready_back"}, 64'(resp_ready), 64'h1);
    m_resp = d;
    m_busy = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [DW-1:0] o;
    logic [DW-1:0] v;
    logic [7:0]    b;
    logic [4:0]    code;
    logic          d;

    model_reset();
    repeat (3) @(negedge clk);
    check("rst_tdo", 64'(tdo), 64'h0);
    check("rst_req_valid", 64'(req_valid), 64'h0);
    check("rst_req_data", 64'(req_data), 64'h0);
    check("rst_resp_ready", 64'(resp_ready), 64'h1);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // IDCODE selected out of reset
    reset_tap();
    scan_dr('0, 32, o);
    check("idcode", 64'(o[31:0]), 64'h1e200a6d);
    set_ir(5'h01, "ir_capture_idcode");
    scan_dr('0, 32, o);
    check("idcode_again", 64'(o[31:0]), 64'h1e200a6d);

    // DTMCS readback
    set_ir(5'h10, "ir_capture_dtmcs");
    scan_dr('0, 32, o);
    check("dtmcs_read", 64'(o[31:0]), 64'(model_dtmcs_capture()));

    // DMI write, held request
    set_ir(5'h11, "ir_capture_dmi");
    v = {6'h10, 32'h0, 2'b10};
    dmi_scan(v, "dmi_wr");
    check("dmi_wr_data_const", 64'(req_data), 64'h4000000002);
    accept_req(10, "dmi_wr");
    respond(32'h1234_5678, "dmi_wr");

    // DMI read and response readback
    dmi_scan({6'h11, 32'h0, 2'b01}, "dmi_rd");
    accept_req(2, "dmi_rd");
    respond(32'h00400c82, "dmi_rd");
    dmi_scan({6'h00, 32'h0, 2'b00}, "dmi_nop");
    // the nop capture above already used the model; also check the literal readback
    scan_dr('0, DW, o);
    check("dmi_readback_const", 64'(o), 64'({6'h11, 32'h00400c82, 2'b00}));

    // Second request while busy is dropped
    dmi_scan({6'h05, 32'h0, 2'b01}, "busy_first");
    accept_req(1, "busy_first");
    dmi_scan({6'h07, 32'hdead_beef, 2'b01}, "busy_second");
    repeat (5) @(negedge clk);
    check("busy_no_valid", 64'(req_valid), 64'h0);
    dmi_scan({6'h3f, 32'h0, 2'b00}, "busy_status");
    respond(32'hcafe_f00d, "busy");
    dmi_scan({6'h00, 32'h0, 2'b00}, "after_resp");
    set_ir(5'h10, "ir_capture_dtmcs2");
    scan_dr(DW'(32'h0001_0000), 32, o);
    check("dtmcs_status", 64'(o[31:0]), 64'(model_dtmcs_capture()));
    model_dtmcs_update(32'h0001_0000);
    set_ir(5'h11, "ir_capture_dmi2");
    dmi_scan({6'h00, 32'h0, 2'b00}, "after_dmireset");

    // Randomized DMI traffic
    for (int i = 0; i < 8; i++) begin
      v = {6'($urandom), 32'($urandom), 2'($urandom_range(1, 3))};
      dmi_scan(v, "rnd");
      if (m_issue) accept_req($urandom_range(0, 6), "rnd");
      respond(32'($urandom), "rnd");
    end
    dmi_scan({6'h00, 32'h0, 2'b00}, "rnd_final");

    // BYPASS: 0x1f with 0xA5, then random codes and bytes
    set_ir(5'h1f, "ir_capture_bypass");
    scan_dr(DW'(8'hA5), 8, o);
    check("bypass_a5", 64'(o[7:0]), 64'h4A);
    for (int i = 0; i < 4; i++) begin
      do code = 5'($urandom); while (code == 5'h01 || code == 5'h10 || code == 5'h11);
      b = 8'($urandom);
      set_ir(code, "ir_capture_rnd");
      scan_dr(DW'(b), 8, o);
      check("bypass_rnd", 64'(o[7:0]), 64'({b[6:0], 1'b0}));
    end

    // Reset in the middle of a DMI Shift-DR with a request pending
    set_ir(5'h11, "ir_capture_dmi3");
    dmi_scan({6'h2a, 32'h0, 2'b01}, "pre_reset");
    tck_cycle(1'b1, 1'b0, d);
    tck_cycle(1'b0, 1'b0, d);
    tck_cycle(1'b0, 1'b0, d);
    check("shift_tdo_busy", 64'(tdo), 64'h1);
    rst = 1'b0;
    #1;
    check("midrst_tdo", 64'(tdo), 64'h0);
    check("midrst_req_valid", 64'(req_valid), 64'h0);
    check("midrst_req_data", 64'(req_data), 64'h0);
    check("midrst_resp_ready", 64'(resp_ready), 64'h1);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    tms = 1'b1;
    tdi = 1'b0;
    repeat (4) @(negedge clk);
    reset_tap();
    scan_dr('0, 32, o);
    check("idcode_after_rst", 64'(o[31:0]), 64'h1e200a6d);
    set_ir(5'h11, "ir_capture_dmi4");
    dmi_scan({6'h00, 32'h0, 2'b00}, "dmi_after_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
